// File: rtl/seg7_pkg.sv
// Shared types and sizing helpers for the seg7 display arbiter.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } arb_state_t;

    localparam int HOLD_CYCLES_DFLT = 100_000_000;
    localparam int HOLD_CNT_W_DFLT  = $clog2(HOLD_CYCLES_DFLT);

    // Hold counter must represent HOLD_CYCLES-1.
    function automatic int hold_cnt_w(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting, non-excluded index
// scanning upward from start and wrapping modulo N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    input  logic [N-1:0]         excl,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int            pos;
    logic [IW-1:0] j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            j = IW'(pos);
            if (!valid && req[j] && !excl[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/seg7_arbiter.sv
// Time-sliced round-robin owner of the 8-digit seg7 driver inputs, with a
// minimum hold per grant and per-requester digit blinking.
//
// state | meaning
// IDLE  | no owner, display dark
// HOLD  | owner granted, hold counter running, other requests ignored
// OPEN  | hold expired, owner keeps display until released or preempted
module seg7_arbiter
    import seg7_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DFLT,
    parameter int BLINK_W     = 25
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     blink,
    input  logic [32*NREQ-1:0]  x_in,
    input  logic [8*NREQ-1:0]   aen_in,
    input  logic [8*NREQ-1:0]   dp_in,
    output logic [NREQ-1:0]     gnt,
    output logic [31:0]         x,
    output logic [7:0]          aen,
    output logic [7:0]          dp_en,
    output logic                busy
);

    localparam int IW     = $clog2(NREQ);
    localparam int HOLD_W = hold_cnt_w(HOLD_CYCLES);

    arb_state_t          state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IW-1:0]       last_q, last_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q;
    logic [31:0]         x_q, x_d;
    logic [7:0]          aen_q, aen_d;
    logic [7:0]          dp_q, dp_d;

    logic [IW-1:0]       start_idx;
    logic [NREQ-1:0]     excl_mask;
    logic                pick_valid;
    logic [IW-1:0]       pick_idx;
    logic                owner_req;
    logic                phase;

    // The owner is always the most recent winner, so last_q doubles as the
    // owner index whenever a grant is active.
    assign start_idx = (int'(last_q) == NREQ - 1) ? '0 : last_q + IW'(1);
    assign excl_mask = (state_q == ST_IDLE) ? '0 : (NREQ'(1) << last_q);
    assign owner_req = req[last_q];
    assign phase     = blink_cnt_q[BLINK_W-1];

    rr_pick #(
        .N (NREQ)
    ) u_pick (
        .req   (req),
        .start (start_idx),
        .excl  (excl_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
                    last_d     = pick_idx;
                    gnt_d      = NREQ'(1) << pick_idx;
                end
            end
            ST_HOLD, ST_OPEN: begin
                if (!owner_req || (state_q == ST_OPEN && pick_valid)) begin
                    if (pick_valid) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
                        last_d     = pick_idx;
                        gnt_d      = NREQ'(1) << pick_idx;
                    end else begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                        gnt_d      = '0;
                    end
                end else if (state_q == ST_HOLD) begin
                    // Leaving on the step to zero makes the grant last exactly
                    // HOLD_CYCLES cycles before OPEN can rotate.
                    if (hold_cnt_q <= HOLD_W'(1)) begin
                        state_d    = ST_OPEN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
                gnt_d      = '0;
            end
        endcase
    end

    always_comb begin
        x_d   = '0;
        aen_d = '0;
        dp_d  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                x_d   = x_in[32*i +: 32];
                dp_d  = dp_in[8*i +: 8];
                aen_d = aen_in[8*i +: 8] & ~{8{blink[i] & phase}};
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            last_q      <= IW'(NREQ - 1);
            gnt_q       <= '0;
            blink_cnt_q <= '0;
            x_q         <= '0;
            aen_q       <= '0;
            dp_q        <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            x_q         <= x_d;
            aen_q       <= aen_d;
            dp_q        <= dp_d;
        end
    end

    assign gnt   = gnt_q;
    assign x     = x_q;
    assign aen   = aen_q;
    assign dp_en = dp_q;
    assign busy  = |gnt_q;

endmodule
